bit_output: RTL
===============

# bit_output

Presents a 64-bit result (DES ciphertext/plaintext) to the user one hex nibble at a time on a seven-segment digit, most-significant nibble first. The user steps through the 16 nibbles with a pushbutton. The block is the output-side counterpart of the switch/button nibble-entry path. It sits between the DES core's result register and the board's HEX display and LEDs.

## Interface
Parameters:
- AUTO_PERIOD, 50000000: clock cycles between automatic advances; only used when AUTO_ADVANCE_EN is defined.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- values_in  input  64  result word; sampled only on the cycle load is high.
- load  input  1  active-high, one-cycle strobe from the DES controller; captures values_in and starts a display pass.
- nextButton  input  1  raw pushbutton, active-low (0 = pressed).
- seg  output  7  active-low segments {g,f,e,d,c,b,a} showing the current nibble; blank = 7'b1111111.
- nibble  output  4  current nibble value (for LEDs).
- nShown  output  5  index of the nibble being shown, 1..16; 0 when idle.
- done  output  1  high after the user steps past nibble 16.

## Operation
- The clock is one clk; reset is asynchronous and active-low (rst).
- Reset values:
  - state IDLE, shift register 0, nShown 0, nibble 0, seg 7'b1111111, done 0
  - pressed flag 1, synchronizer flops 1, auto counter 0
- nextButton passes through a 2-flop synchronizer, reset to 1. Only the synchronized signal btn_s is used.
- Press detection:
  - A press is counted when btn_s == 0 and the pressed flag == 0. Counting a press sets pressed.
  - pressed clears on any cycle with btn_s == 1.
  - One advance per press, regardless of hold length.
- State machine (IDLE, SHOW, DONE):
  - IDLE: seg blank, nShown 0. Presses are ignored.
  - Any state, load == 1:
    - shift register <= values_in, nShown <= 1, done <= 0, pressed <= 1, auto counter <= 0
    - state <= SHOW
    - load takes priority over a press in the same cycle.
  - SHOW: the display shows shift register [63:60].
    - Press with nShown < 16: shift register <= shift register << 4 (zero fill), nShown <= nShown + 1.
    - Press with nShown == 16: state <= DONE, done <= 1.
  - DONE: seg blank, nibble 0, nShown holds 16, done holds 1. Presses are ignored. Only load or rst leave DONE.
- Decode (active-low): 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000, A→0001000, b→0000011, C→1000110, d→0100001, E→0000110, F→0001110.
- Width rule: nShown is 5 bits, never exceeds 16, no wrap.

## Timing
- All outputs are registered, including seg and nibble.
- load high at edge N: seg/nibble/nShown reflect the new word after edge N.
- Button press to advance: nextButton low before edge N gives btn_s low after edge N+1. The advance is visible after edge N+2, so latency is 3 edges.
- Releases have the same 2-cycle synchronizer delay before pressed clears.
- A button held through load does not advance until it has been released and pressed again.
- rst low mid-pass: immediate return to reset values, with no clock needed.

## Configuration
- AUTO_ADVANCE_EN defined:
  - In SHOW, a counter of width $clog2(AUTO_PERIOD) increments every cycle.
  - When it reaches AUTO_PERIOD-1 it causes exactly the same action as a press, then resets to 0.
  - The counter also resets on any button advance and on load. It holds at 0 outside SHOW.
  - If a button press and an auto-advance land in the same cycle, the result is a single advance.
- AUTO_ADVANCE_EN undefined: no counter is synthesized; only the button advances. AUTO_PERIOD is unused.

## Test plan
- Reset: rst low with no clock → seg 7'b1111111, nShown 0, done 0, nibble 0.
- Load and first nibble: load values_in 64'h0123456789ABCDEF → next cycle nibble 0, seg 1000000, nShown 1.
- Full pass: 16 clean presses (each ≥4 cycles low, ≥4 high) → nibbles 1..F in order, nShown 2..16. The 16th press sets done 1, seg blank.
- Held button: hold nextButton low for 100 cycles → exactly one advance. A press held across load → no advance until release and re-press.
- Reload priority: load 64'hFFFF000000000000 in the same cycle as a counted press during SHOW → nShown 1, nibble F. The press is not applied.
- Auto-advance (AUTO_ADVANCE_EN, AUTO_PERIOD=8): load 64'h0123456789ABCDEF with no presses → nShown increments every 8 cycles, and done rises 8 cycles after nShown reaches 16.

Source files
------------

// File: rtl/bit_output_if.sv
// rtl/bit_output_if.sv - result-word load and nibble display signal bundle for bit_output
interface bit_output_if;
  logic [63:0] values_in;
  logic        load;
  logic        nextButton;
  logic [6:0]  seg;
  logic [3:0]  nibble;
  logic [4:0]  nShown;
  logic        done;

  modport master (
    output values_in, load, nextButton,
    input  seg, nibble, nShown, done
  );

  modport slave (
    input  values_in, load, nextButton,
    output seg, nibble, nShown, done
  );
endinterface

// File: rtl/bit_output.sv
// rtl/bit_output.sv - steps a 64-bit result onto a seven-segment digit one nibble per press (optional AUTO_ADVANCE_EN)
module bit_output #(
  parameter int AUTO_PERIOD = 50000000
) (
  input logic        clk,
  input logic        rst,
  bit_output_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SHOW, DONE} state_t;

  localparam logic [6:0] BLANK = 7'b1111111;

  state_t      state, state_next;
  logic [63:0] shift, shift_next;
  logic [4:0]  shown, shown_next;
  logic        done_r, done_next;
  logic [6:0]  seg_r, seg_next;
  logic [3:0]  nibble_r, nibble_next;

  logic sync1, btn_s;
  logic pressed;
  logic press;
  logic auto_fire;
  logic advance;

  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0: decode = 7'b1000000;
      4'h1: decode = 7'b1111001;
      4'h2: decode = 7'b0100100;
      4'h3: decode = 7'b0110000;
      4'h4: decode = 7'b0011001;
      4'h5: decode = 7'b0010010;
      4'h6: decode = 7'b0000010;
      4'h7: decode = 7'b1111000;
      4'h8: decode = 7'b0000000;
      4'h9: decode = 7'b0010000;
      4'hA: decode = 7'b0001000;
      4'hB: decode = 7'b0000011;
      4'hC: decode = 7'b1000110;
      4'hD: decode = 7'b0100001;
      4'hE: decode = 7'b0000110;
      default: decode = 7'b0001110;
    endcase
  endfunction

  // Two-flop synchronizer for the raw pushbutton; idles high (released).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b1;
      btn_s <= 1'b1;
    end else begin
      sync1 <= bus.nextButton;
      btn_s <= sync1;
    end
  end

  assign press = !btn_s && !pressed;

  // Pressed flag: one press per low period; load re-arms it so a held button must be released first.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pressed <= 1'b1;
    end else if (bus.load) begin
      pressed <= 1'b1;
    end else if (btn_s) begin
      pressed <= 1'b0;
    end else if (press) begin
      pressed <= 1'b1;
    end
  end

`ifdef AUTO_ADVANCE_EN
  localparam int CW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
  logic [CW-1:0] auto_cnt;

  assign auto_fire = (state == SHOW) && (auto_cnt == CW'(AUTO_PERIOD - 1));

  // Auto-advance timer: runs only while showing, restarts on every advance and on load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      auto_cnt <= '0;
    end else if (bus.load || state != SHOW || advance) begin
      auto_cnt <= '0;
    end else begin
      auto_cnt <= auto_cnt + 1'b1;
    end
  end
`else
  // No timer in this build; the parameter stays referenced but has no effect.
  assign auto_fire = 1'b0 & (AUTO_PERIOD != 0);
`endif

  // A button press and a timer expiry in the same cycle merge into one advance.
  assign advance = (state == SHOW) && (press || auto_fire);

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      shift    <= '0;
      shown    <= '0;
      done_r   <= 1'b0;
      seg_r    <= BLANK;
      nibble_r <= '0;
    end else begin
      state    <= state_next;
      shift    <= shift_next;
      shown    <= shown_next;
      done_r   <= done_next;
      seg_r    <= seg_next;
      nibble_r <= nibble_next;
    end
  end

  // Next-state logic: load wins over any advance in the same cycle.
  always_comb begin
    state_next = state;
    shift_next = shift;
    shown_next = shown;
    done_next  = done_r;
    if (bus.load) begin
      state_next = SHOW;
      shift_next = bus.values_in;
      shown_next = 5'd1;
      done_next  = 1'b0;
    end else begin
      case (state)
        SHOW: begin
          if (advance) begin
            if (shown == 5'd16) begin
              state_next = DONE;
              done_next  = 1'b1;
            end else begin
              shift_next = {shift[59:0], 4'h0};
              shown_next = shown + 5'd1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Display values computed from the upcoming state so seg and nibble are registered yet current.
  always_comb begin
    seg_next    = BLANK;
    nibble_next = 4'h0;
    if (state_next == SHOW) begin
      nibble_next = shift_next[63:60];
      seg_next    = decode(shift_next[63:60]);
    end
  end

  assign bus.seg    = seg_r;
  assign bus.nibble = nibble_r;
  assign bus.nShown = shown;
  assign bus.done   = done_r;

endmodule
